// File: rtl/accelerator_vector_calculus_controller_if.sv
// Job/stream bundle between the NTM control, the vector data streams and the
// vector calculus controller.
interface accelerator_vector_calculus_controller_if #(
    parameter int unsigned DataSize    = 64,
    parameter int unsigned ControlSize = 4
);
    logic                   start;
    logic                   ready;
    logic [ControlSize-1:0] mode;
    logic [DataSize-1:0]    length;
    logic                   data_enable;
    logic                   data_in_enable;
    logic [DataSize-1:0]    data_in;
    logic                   data_out_enable;
    logic [DataSize-1:0]    data_out;
    logic [DataSize-1:0]    index_out;

    modport master (
        output start, mode, length, data_in_enable, data_in,
        input  ready, data_enable, data_out_enable, data_out, index_out
    );

    modport slave (
        input  start, mode, length, data_in_enable, data_in,
        output ready, data_enable, data_out_enable, data_out, index_out
    );
endinterface

// File: rtl/accelerator_vector_calculus_controller.sv
// Job sequencer for the vector calculus path: streams LENGTH elements through a
// shared difference/accumulate datapath, one registered result per accepted input.
module accelerator_vector_calculus_controller #(
    parameter int unsigned DataSize    = 64,
    parameter int unsigned ControlSize = 4
) (
    input logic clk,
    input logic rst,
    accelerator_vector_calculus_controller_if.slave ctrl_io
);

    typedef enum logic [1:0] {StStarter, StInput, StEnder} state_e;

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic [DataSize-1:0] length_q, length_d;
    logic [DataSize-1:0] count_q, count_d;
    logic [DataSize-1:0] prev_q, prev_d;
    logic [DataSize-1:0] acc_q, acc_d;
    logic                ready_q, ready_d;
    logic                data_enable_q, data_enable_d;
    logic                strobe_q, strobe_d;
    logic [DataSize-1:0] data_out_q, data_out_d;
    logic [DataSize-1:0] index_out_q, index_out_d;

    logic                accept;
    logic [DataSize-1:0] result;

    // Only mode bit 0 is decoded; the reserved bits are deliberately dropped.
    logic unused_mode;
    assign unused_mode = ^ctrl_io.mode[ControlSize-1:1];

    assign accept = data_enable_q & ctrl_io.data_in_enable;
    assign result = mode_q ? (acc_q + ctrl_io.data_in) : (ctrl_io.data_in - prev_q);

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        length_d      = length_q;
        count_d       = count_q;
        prev_d        = prev_q;
        acc_d         = acc_q;
        ready_d       = ready_q;
        data_enable_d = data_enable_q;
        strobe_d      = 1'b0;
        data_out_d    = data_out_q;
        index_out_d   = index_out_q;

        unique case (state_q)
            // The ender cycle already shows READY=1, so it takes a new job too.
            StStarter, StEnder: begin
                state_d = StStarter;
                if (ctrl_io.start && (ctrl_io.length != '0)) begin
                    state_d       = StInput;
                    mode_d        = ctrl_io.mode[0];
                    length_d      = ctrl_io.length;
                    count_d       = '0;
                    prev_d        = '0;
                    acc_d         = '0;
                    ready_d       = 1'b0;
                    data_enable_d = 1'b1;
                end
            end
            StInput: begin
                if (accept) begin
                    strobe_d    = 1'b1;
                    data_out_d  = result;
                    index_out_d = count_q;
                    count_d     = count_q + 1'b1;
                    if (mode_q) begin
                        acc_d = result;
                    end else begin
                        prev_d = ctrl_io.data_in;
                    end
                    if (count_q == (length_q - 1'b1)) begin
                        state_d       = StEnder;
                        data_enable_d = 1'b0;
                        ready_d       = 1'b1;
                    end
                end
            end
            default: state_d = StStarter;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StStarter;
            mode_q        <= 1'b0;
            length_q      <= '0;
            count_q       <= '0;
            prev_q        <= '0;
            acc_q         <= '0;
            ready_q       <= 1'b1;
            data_enable_q <= 1'b0;
            strobe_q      <= 1'b0;
            data_out_q    <= '0;
            index_out_q   <= '0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            length_q      <= length_d;
            count_q       <= count_d;
            prev_q        <= prev_d;
            acc_q         <= acc_d;
            ready_q       <= ready_d;
            data_enable_q <= data_enable_d;
            strobe_q      <= strobe_d;
            data_out_q    <= data_out_d;
            index_out_q   <= index_out_d;
        end
    end

    assign ctrl_io.ready           = ready_q;
    assign ctrl_io.data_enable     = data_enable_q;
    assign ctrl_io.data_out_enable = strobe_q;
    assign ctrl_io.data_out        = data_out_q;
    assign ctrl_io.index_out       = index_out_q;

endmodule

// File: tb/tb_accelerator_vector_calculus_controller.sv
// Self-checking bench: table of jobs plus hand-written control corner cases,
// with a cycle-accurate scoreboard of expected result strobes.
module tb_accelerator_vector_calculus_controller;

    localparam int unsigned DW = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    accelerator_vector_calculus_controller_if #(.DataSize(DW), .ControlSize(4)) bus ();

    accelerator_vector_calculus_controller #(
        .DataSize   (DW),
        .ControlSize(4)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .ctrl_io(bus.slave)
    );

    typedef struct {
        logic [63:0]     data;
        logic [63:0]     idx;
        logic            last;
        longint unsigned due;
    } exp_t;

    typedef struct {
        logic        mode;
        int          len;
        logic [63:0] din[4];
        logic [63:0] dout[4];
        int          stall;
    } job_t;

    exp_t            sb_q[$];
    exp_t            mon_e;
    job_t            jobs[4];
    int              checks = 0;
    int              errors = 0;
    int              strobes = 0;
    int              s0;
    longint unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every strobe must match the head entry, in its due cycle.
    always @(negedge clk) begin
        if (!rst && bus.data_out_enable) begin
            strobes++;
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got data_out=%0h index=%0h expected none",
                         bus.data_out, bus.index_out);
            end else begin
                mon_e = sb_q.pop_front();
                check64("data_out", bus.data_out, mon_e.data);
                check64("index_out", bus.index_out, mon_e.idx);
                check64("strobe_cycle", cyc, mon_e.due);
                if (mon_e.last) check64("ready_on_last_strobe", {63'd0, bus.ready}, 64'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input logic m, input logic [63:0] len);
        tick();
        bus.start  = 1'b1;
        bus.mode   = {3'b101, m};
        bus.length = len;
        tick();
        bus.start  = 1'b0;
        bus.mode   = {3'b010, ~m};
        bus.length = 64'd77;
    endtask

    task automatic wait_de();
        int n = 0;
        while (!bus.data_enable && n < 20) begin
            tick();
            n++;
        end
        check64("data_enable_rise", {63'd0, bus.data_enable}, 64'd1);
    endtask

    task automatic feed(input logic [63:0] d, input logic [63:0] e, input logic [63:0] i,
                        input logic last, input int stall);
        bus.data_in_enable = 1'b1;
        bus.data_in        = d;
        sb_q.push_back('{data: e, idx: i, last: last, due: cyc + 1});
        tick();
        bus.data_in_enable = 1'b0;
        bus.data_in        = 64'hDEAD_BEEF_0000_0000 | 64'($urandom);
        repeat (stall) tick();
    endtask

    task automatic drain(input string name);
        repeat (3) tick();
        check64(name, 64'(sb_q.size()), 64'd0);
        check64({name, "_ready"}, {63'd0, bus.ready}, 64'd1);
        check64({name, "_de"}, {63'd0, bus.data_enable}, 64'd0);
    endtask

    task automatic run_job(input job_t j, input string name);
        start_job(j.mode, 64'(j.len));
        wait_de();
        for (int i = 0; i < j.len; i++) begin
            feed(j.din[i], j.dout[i], 64'(i), (i == j.len - 1), j.stall);
        end
        drain(name);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        jobs[0].mode = 1'b0; jobs[0].len = 4; jobs[0].stall = 0;
        jobs[0].din  = '{64'd5, 64'd8, 64'd8, 64'd3};
        jobs[0].dout = '{64'd5, 64'd3, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB};
        jobs[1].mode = 1'b1; jobs[1].len = 4; jobs[1].stall = 2;
        jobs[1].din  = '{64'd1, 64'd2, 64'd3, 64'd4};
        jobs[1].dout = '{64'd1, 64'd3, 64'd6, 64'd10};
        jobs[2].mode = 1'b1; jobs[2].len = 2; jobs[2].stall = 0;
        jobs[2].din  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 64'd0};
        jobs[2].dout = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 64'd0};
        jobs[3].mode = 1'b0; jobs[3].len = 2; jobs[3].stall = 0;
        jobs[3].din  = '{64'd7, 64'd7, 64'd0, 64'd0};
        jobs[3].dout = '{64'd7, 64'd0, 64'd0, 64'd0};

        rst = 1'b1;
        bus.start = 1'b0; bus.mode = '0; bus.length = '0;
        bus.data_in_enable = 1'b0; bus.data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check64("rst_ready", {63'd0, bus.ready}, 64'd1);
        check64("rst_de", {63'd0, bus.data_enable}, 64'd0);
        check64("rst_strobe", {63'd0, bus.data_out_enable}, 64'd0);
        check64("rst_data_out", bus.data_out, 64'd0);
        check64("rst_index_out", bus.index_out, 64'd0);
        rst = 1'b0;

        for (int k = 0; k < 3; k++) run_job(jobs[k], $sformatf("job%0d_drain", k));

        // START with zero length is ignored.
        s0 = strobes;
        tick();
        bus.start = 1'b1; bus.length = '0; bus.mode = 4'd1;
        tick();
        bus.start = 1'b0;
        check64("len0_ready", {63'd0, bus.ready}, 64'd1);
        check64("len0_de", {63'd0, bus.data_enable}, 64'd0);
        repeat (3) tick();
        check64("len0_no_strobe", 64'(strobes - s0), 64'd0);

        // Input valid while idle is ignored.
        s0 = strobes;
        bus.data_in_enable = 1'b1; bus.data_in = 64'd99;
        repeat (3) tick();
        bus.data_in_enable = 1'b0;
        repeat (2) tick();
        check64("idle_din_no_strobe", 64'(strobes - s0), 64'd0);

        // START pulsed mid-job must not disturb the running job.
        start_job(1'b0, 64'd3);
        wait_de();
        s0 = strobes;
        feed(64'd10, 64'd10, 64'd0, 1'b0, 0);
        bus.start = 1'b1; bus.length = 64'd5; bus.mode = 4'd1;
        feed(64'd13, 64'd3, 64'd1, 1'b0, 1);
        bus.start = 1'b0;
        feed(64'd20, 64'd7, 64'd2, 1'b1, 0);
        drain("midstart_drain");
        check64("midstart_strobes", 64'(strobes - s0), 64'd3);

        // Reset in the middle of a differentiation job.
        start_job(1'b0, 64'd5);
        wait_de();
        feed(64'd4, 64'd4, 64'd0, 1'b0, 0);
        feed(64'd9, 64'd5, 64'd1, 1'b0, 0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check64("midrst_ready", {63'd0, bus.ready}, 64'd1);
        check64("midrst_de", {63'd0, bus.data_enable}, 64'd0);
        check64("midrst_strobe", {63'd0, bus.data_out_enable}, 64'd0);
        check64("midrst_data_out", bus.data_out, 64'd0);
        check64("midrst_index_out", bus.index_out, 64'd0);
        tick();
        rst = 1'b0;
        check64("midrst_sb_empty", 64'(sb_q.size()), 64'd0);
        run_job(jobs[3], "postrst_drain");

        // START held across the ender cycle starts the next job at once.
        start_job(1'b0, 64'd1);
        wait_de();
        bus.start = 1'b1; bus.mode = 4'd1; bus.length = 64'd1;
        feed(64'd4, 64'd4, 64'd0, 1'b1, 0);
        check64("b2b_ender_ready", {63'd0, bus.ready}, 64'd1);
        check64("b2b_ender_de", {63'd0, bus.data_enable}, 64'd0);
        tick();
        bus.start = 1'b0;
        check64("b2b_second_de", {63'd0, bus.data_enable}, 64'd1);
        feed(64'd9, 64'd9, 64'd0, 1'b1, 0);
        drain("b2b_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
